// File: rtl/mem_lat_pkg.sv
// mem_lat_pkg: shared request-entry type and age counter width for the latency bridge
package mem_lat_pkg;
  localparam int AGE_W = 8;
  typedef struct packed {
    logic             rw;
    logic [AGE_W-1:0] age;
  } req_entry_t;
endpackage

// File: rtl/mem_rsp_skid.sv
// mem_rsp_skid: two-entry in-order response buffer whose input ready depends only on registered occupancy
module mem_rsp_skid #(
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [TAG_WIDTH-1:0]  in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [TAG_WIDTH-1:0]  out_tag_o
);
  logic [DATA_WIDTH-1:0] data_q [2];
  logic [TAG_WIDTH-1:0]  tag_q  [2];
  logic                  wr_q, wr_d, rd_q, rd_d, push, pop;
  logic [1:0]            cnt_q, cnt_d;
  assign in_ready_o  = cnt_q == 2'd0;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = data_q[rd_q];
  assign out_tag_o   = tag_q[rd_q];
  // handshake decode and next pointer/occupancy
  always_comb begin
    push  = in_valid_i && in_ready_o;
    pop   = out_valid_o && out_ready_i;
    wr_d  = push ? ~wr_q : wr_q;
    rd_d  = pop ? ~rd_q : rd_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  // storage and pointer registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_q] <= in_data_i;
        tag_q[wr_q]  <= in_tag_i;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_lat_bridge.sv
// mem_lat_bridge: delays each memory request by a fixed minimum latency before issuing it downstream
module mem_lat_bridge
  import mem_lat_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_req_valid_i,
  output logic                    s_req_ready_o,
  input  logic                    s_req_rw_i,
  input  logic [DATA_WIDTH/8-1:0] s_req_byteen_i,
  input  logic [ADDR_WIDTH-1:0]   s_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   s_req_data_i,
  input  logic [TAG_WIDTH-1:0]    s_req_tag_i,
  output logic                    s_rsp_valid_o,
  input  logic                    s_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   s_rsp_data_o,
  output logic [TAG_WIDTH-1:0]    s_rsp_tag_o,
  output logic                    m_req_valid_o,
  input  logic                    m_req_ready_i,
  output logic                    m_req_rw_o,
  output logic [DATA_WIDTH/8-1:0] m_req_byteen_o,
  output logic [ADDR_WIDTH-1:0]   m_req_addr_o,
  output logic [DATA_WIDTH-1:0]   m_req_data_o,
  output logic [TAG_WIDTH-1:0]    m_req_tag_o,
  input  logic                    m_rsp_valid_i,
  output logic                    m_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]   m_rsp_data_i,
  input  logic [TAG_WIDTH-1:0]    m_rsp_tag_i,
  output logic                    busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  // rw and age travel in the shared entry type; parameter-sized payload sits in parallel arrays
  req_entry_t            hdr_q  [DEPTH];
  logic [BW-1:0]         be_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  push, pop;
  assign s_req_ready_o  = cnt_q != FULL;
  assign m_req_valid_o  = (cnt_q != '0) && (hdr_q[rd_q].age == LAT);
  assign m_req_rw_o     = hdr_q[rd_q].rw;
  assign m_req_byteen_o = be_q[rd_q];
  assign m_req_addr_o   = addr_q[rd_q];
  assign m_req_data_o   = data_q[rd_q];
  assign m_req_tag_o    = tag_q[rd_q];
  assign busy_o         = (cnt_q != '0) || s_rsp_valid_o;
  // queue handshake decode and next pointer/occupancy
  always_comb begin
    push  = s_req_valid_i && s_req_ready_o;
    pop   = m_req_valid_o && m_req_ready_i;
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // queue storage: new entries start at age 0, all others age toward LATENCY and hold there
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        hdr_q[i]  <= '0;
        be_q[i]   <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_q == PW'(i)) begin
          hdr_q[i]  <= '{rw: s_req_rw_i, age: '0};
          be_q[i]   <= s_req_byteen_i;
          addr_q[i] <= s_req_addr_i;
          data_q[i] <= s_req_data_i;
          tag_q[i]  <= s_req_tag_i;
        end else if (hdr_q[i].age != LAT) begin
          hdr_q[i].age <= hdr_q[i].age + 1'b1;
        end
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  mem_rsp_skid #(
    .DATA_WIDTH(DATA_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rsp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (m_rsp_valid_i),
    .in_ready_o (m_rsp_ready_o),
    .in_data_i  (m_rsp_data_i),
    .in_tag_i   (m_rsp_tag_i),
    .out_valid_o(s_rsp_valid_o),
    .out_ready_i(s_rsp_ready_i),
    .out_data_o (s_rsp_data_o),
    .out_tag_o  (s_rsp_tag_o)
  );
endmodule

// File: tb/tb_mem_lat_bridge.sv
// tb_mem_lat_bridge: randomized bench comparing the bridge against a timestamped transaction model
module tb_mem_lat_bridge;
  localparam int DW = 64;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int D  = 4;
  localparam int L  = 8;
  localparam int BW = DW / 8;
  logic clk = 1'b0;
  logic rst_i;
  logic s_req_valid_i, s_req_ready_o, s_req_rw_i;
  logic [BW-1:0] s_req_byteen_i, m_req_byteen_o;
  logic [AW-1:0] s_req_addr_i, m_req_addr_o;
  logic [DW-1:0] s_req_data_i, m_req_data_o, s_rsp_data_o, m_rsp_data_i;
  logic [TW-1:0] s_req_tag_i, m_req_tag_o, s_rsp_tag_o, m_rsp_tag_i;
  logic s_rsp_valid_o, s_rsp_ready_i, m_req_valid_o, m_req_ready_i, m_req_rw_o;
  logic m_rsp_valid_i, m_rsp_ready_o, busy_o;
  always #5 clk = ~clk;
  mem_lat_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(D), .LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_valid_i(s_req_valid_i), .s_req_ready_o(s_req_ready_o), .s_req_rw_i(s_req_rw_i),
    .s_req_byteen_i(s_req_byteen_i), .s_req_addr_i(s_req_addr_i), .s_req_data_i(s_req_data_i),
    .s_req_tag_i(s_req_tag_i),
    .s_rsp_valid_o(s_rsp_valid_o), .s_rsp_ready_i(s_rsp_ready_i), .s_rsp_data_o(s_rsp_data_o),
    .s_rsp_tag_o(s_rsp_tag_o),
    .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i), .m_req_rw_o(m_req_rw_o),
    .m_req_byteen_o(m_req_byteen_o), .m_req_addr_o(m_req_addr_o), .m_req_data_o(m_req_data_o),
    .m_req_tag_o(m_req_tag_o),
    .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_ready_o(m_rsp_ready_o), .m_rsp_data_i(m_rsp_data_i),
    .m_rsp_tag_i(m_rsp_tag_i), .busy_o(busy_o)
  );
  typedef struct {
    logic          rw;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            t;
  } req_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;
  req_t rq[$];
  rsp_t rs[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit head_due();
    return rq.size() != 0 && (cyc - rq[0].t) >= L;
  endfunction
  task automatic check_outputs();
    bit mv;
    mv = head_due();
    chk("s_req_ready", 64'(s_req_ready_o), 64'(rq.size() != D));
    chk("m_req_valid", 64'(m_req_valid_o), 64'(mv));
    if (mv) begin
      chk("m_req_rw", 64'(m_req_rw_o), 64'(rq[0].rw));
      chk("m_req_byteen", 64'(m_req_byteen_o), 64'(rq[0].be));
      chk("m_req_addr", 64'(m_req_addr_o), 64'(rq[0].addr));
      chk("m_req_data", m_req_data_o, rq[0].data);
      chk("m_req_tag", 64'(m_req_tag_o), 64'(rq[0].tag));
    end
    chk("m_rsp_ready", 64'(m_rsp_ready_o), 64'(rs.size() == 0));
    chk("s_rsp_valid", 64'(s_rsp_valid_o), 64'(rs.size() != 0));
    if (rs.size() != 0) begin
      chk("s_rsp_data", s_rsp_data_o, rs[0].data);
      chk("s_rsp_tag", 64'(s_rsp_tag_o), 64'(rs[0].tag));
    end
    chk("busy", 64'(busy_o), 64'(rq.size() != 0 || rs.size() != 0));
  endtask
  task automatic step(input int pv, input int pmr, input int psr, input int prs);
    bit push, pop, rpush, rpop;
    @(negedge clk);
    check_outputs();
    s_req_valid_i  = $urandom_range(99) < pv;
    s_req_rw_i     = $urandom_range(1);
    s_req_byteen_i = BW'($urandom);
    s_req_addr_i   = AW'($urandom);
    s_req_data_i   = {$urandom, $urandom};
    s_req_tag_i    = TW'($urandom);
    m_req_ready_i  = $urandom_range(99) < pmr;
    s_rsp_ready_i  = $urandom_range(99) < psr;
    m_rsp_valid_i  = $urandom_range(99) < prs;
    m_rsp_data_i   = {$urandom, $urandom};
    m_rsp_tag_i    = TW'($urandom);
    push  = s_req_valid_i && rq.size() != D;
    pop   = head_due() && m_req_ready_i;
    rpush = m_rsp_valid_i && rs.size() == 0;
    rpop  = rs.size() != 0 && s_rsp_ready_i;
    @(posedge clk);
    cyc++;
    if (pop) void'(rq.pop_front());
    if (push) rq.push_back('{s_req_rw_i, s_req_byteen_i, s_req_addr_i, s_req_data_i, s_req_tag_i, cyc});
    if (rpop) void'(rs.pop_front());
    if (rpush) rs.push_back('{m_rsp_data_i, m_rsp_tag_i});
  endtask
  task automatic do_reset();
    @(negedge clk);
    s_req_valid_i = 1'b0;
    m_rsp_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("rst s_req_ready", 64'(s_req_ready_o), 64'd1);
    chk("rst m_req_valid", 64'(m_req_valid_o), 64'd0);
    chk("rst s_rsp_valid", 64'(s_rsp_valid_o), 64'd0);
    chk("rst m_rsp_ready", 64'(m_rsp_ready_o), 64'd1);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst m_req_addr", 64'(m_req_addr_o), 64'd0);
    chk("rst m_req_data", m_req_data_o, 64'd0);
    chk("rst m_req_tag", 64'(m_req_tag_o), 64'd0);
    chk("rst s_rsp_data", s_rsp_data_o, 64'd0);
    chk("rst s_rsp_tag", 64'(s_rsp_tag_o), 64'd0);
    rq.delete();
    rs.delete();
    @(negedge clk);
    rst_i = 1'b0;
  endtask
  initial begin
    rst_i = 1'b1;
    s_req_valid_i = 1'b0; s_req_rw_i = 1'b0; s_req_byteen_i = '0; s_req_addr_i = '0;
    s_req_data_i = '0; s_req_tag_i = '0; m_req_ready_i = 1'b0; s_rsp_ready_i = 1'b0;
    m_rsp_valid_i = 1'b0; m_rsp_data_i = '0; m_rsp_tag_i = '0;
    do_reset();
    // single request, then idle long enough to see the latency boundary and the issue
    step(100, 0, 100, 0);
    for (int i = 0; i < L + 2; i++) step(0, 0, 100, 0);
    for (int i = 0; i < 3; i++) step(0, 100, 100, 0);
    // fill the queue with downstream stalled, then drain one at a time
    for (int i = 0; i < L + 4; i++) step(100, 0, 100, 0);
    for (int i = 0; i < 2; i++) step(0, 100, 100, 0);
    for (int i = 0; i < 3 * L; i++) step(100, 100, 100, 0);
    // responses held upstream, then released
    for (int i = 0; i < 5; i++) step(0, 100, 0, 100);
    for (int i = 0; i < 5; i++) step(0, 100, 100, 100);
    // reset with requests in flight
    for (int i = 0; i < 3; i++) step(100, 0, 0, 100);
    do_reset();
    for (int i = 0; i < L + 3; i++) step(0, 100, 100, 0);
    // mixed random traffic
    for (int i = 0; i < 3000; i++) step(60, 70, 60, 40);
    for (int i = 0; i < 1000; i++) step(90, 20, 30, 80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_lat_bridge.md
MEM_LAT_BRIDGE -- requirements
Module: mem_lat_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, memory block width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, block address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, request/response tag width.
REQ-004 SHALL have parameter DEPTH, default 4, request queue entries (power of two, >=2).
REQ-005 SHALL have parameter LATENCY, default 8, minimum cycles between request acceptance and downstream issue (1..255).
REQ-006 SHALL have ports as follows; one clock, reset asynchronous active-high:
 clk_i  in  1  clock
 rst_i  in  1  asynchronous active-high reset
 s_req_valid_i/s_req_ready_o  in/out  1  upstream (GPU) request handshake
 s_req_rw_i  in  1  1=write, 0=read
 s_req_byteen_i  in  DATA_WIDTH/8  write byte enables
 s_req_addr_i  in  ADDR_WIDTH  block address
 s_req_data_i  in  DATA_WIDTH  write data
 s_req_tag_i  in  TAG_WIDTH  request tag
 s_rsp_valid_o/s_rsp_ready_i  out/in  1  upstream response handshake
 s_rsp_data_o  out  DATA_WIDTH  read data
 s_rsp_tag_o  out  TAG_WIDTH  response tag
 m_req_valid_o/m_req_ready_i  out/in  1  downstream (RAM) request handshake
 m_req_rw_o, m_req_byteen_o, m_req_addr_o, m_req_data_o, m_req_tag_o  out  as s_req_*  delayed request
 m_rsp_valid_i/m_rsp_ready_o  in/out  1  downstream response handshake
 m_rsp_data_i, m_rsp_tag_i  in  DATA_WIDTH, TAG_WIDTH  RAM response
 busy_o  out  1  any request or response held internally

Function
REQ-007 Request transfer occurs on a rising edge with valid&ready both high; same for all four handshakes.
REQ-008 Request queue SHALL be in-order FIFO of DEPTH entries {rw, byteen, addr, data, tag, age}.
REQ-009 s_req_ready_o = (count != DEPTH); no combinational dependence on m_req_ready_i.
REQ-010 Accepted entry written with age 0; every entry's age increments each edge, saturating at LATENCY.
REQ-011 m_req_valid_o = head valid AND head age == LATENCY; m_req_* fields driven from head entry, stable while valid and not ready.
REQ-012 Consequence: request accepted at edge t first presents m_req_valid_o after edge t+LATENCY; back-to-back accepts issue back-to-back if m_req_ready_i held high.
REQ-013 Simultaneous push and pop in one edge SHALL keep count unchanged; push when full is impossible (ready low).
REQ-014 Read/write pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-015 Writes generate no response; bridge SHALL not track outstanding reads.
REQ-016 Response path SHALL be a 2-entry skid buffer: m_rsp_ready_o registered, high when buffer holds <=1 entry... precisely: m_rsp_ready_o = (rsp_count == 0) registered-equivalent, so no combinational path from s_rsp_ready_i.
REQ-017 s_rsp_valid_o = rsp_count != 0; responses returned in arrival order, data/tag unmodified; min response latency 1 cycle.
REQ-018 busy_o = (count != 0) OR (rsp_count != 0).

Reset
REQ-019 While rst_i high: queue and skid buffer empty, all ages 0, pointers 0; s_req_ready_o=1, m_req_valid_o=0, s_rsp_valid_o=0, m_rsp_ready_o=1, busy_o=0, all data/tag/addr outputs 0.
REQ-020 Reset asserted mid-operation SHALL discard all queued requests and responses immediately (asynchronously).

Structure
REQ-021 Package mem_lat_pkg SHALL hold the request-entry struct typedef and age-width constant.
REQ-022 Response skid buffer SHALL be sub-module mem_rsp_skid (parameters DATA_WIDTH, TAG_WIDTH).

Verification
REQ-023 LATENCY=8: single read addr 0x10 tag 3 accepted at edge 5 -> m_req_valid_o first high after edge 13, fields match, busy_o high until response delivered.
REQ-024 DEPTH=4, m_req_ready_i=0: five back-to-back requests -> four accepted, s_req_ready_o low after 4th; one pop re-asserts ready next cycle.
REQ-025 m_req_ready_i=1: 4 consecutive writes -> 4 consecutive m_req_valid_o cycles, in order, no responses.
REQ-026 s_rsp_ready_i=0, two RAM responses tags 1,2 -> m_rsp_ready_o low after first, both delivered in order once ready high, no loss.
REQ-027 rst_i pulsed with 3 queued requests -> all outputs at reset values in same cycle, no stale m_req_valid_o after release.
